// File: rtl/tinyqv_pkg.sv
// Shared definitions for the TinyQV instruction prefetch slice.
//
// Contents:
//   PF_DEPTH    - default number of halfword entries in the prefetch buffer
//   pf_state_e  - prefetch controller state encoding (RESTART / FETCH / FLUSH)
package tinyqv_pkg;

    localparam int PF_DEPTH = 4;

    typedef enum logic [1:0] {
        PF_RESTART = 2'd0,  // no fetch in progress, ask controller to start one
        PF_FETCH   = 2'd1,  // fetch running, incoming halfwords are buffered
        PF_FLUSH   = 2'd2   // stale fetch running, incoming halfwords are dropped
    } pf_state_e;

endpackage

// File: rtl/tinyqv_hw_fifo.sv
// Halfword shift buffer used by the instruction prefetcher.
//
// Entry 0 is always the head; popping shifts the whole buffer down so the two
// head entries are available at fixed positions without any read pointer.
//
// Ports:
//   clk, rstn  - clock, asynchronous active-low reset
//   clr        - empty the buffer (takes priority over push/pop)
//   push       - append push_data at the tail
//   push_data  - 16-bit halfword to append
//   pop        - number of head entries to remove this cycle (0..2)
//   head0      - entry 0 (head)
//   head1      - entry 1
//   count      - number of valid entries
//
// The caller guarantees pop <= count and never pushes into a full buffer
// unless the same cycle pops at least one entry.
module tinyqv_hw_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          push,
    input  logic [15:0]   push_data,
    input  logic [1:0]    pop,
    output logic [15:0]   head0,
    output logic [15:0]   head1,
    output logic [CW-1:0] count
);

    // Flat storage: entry i lives in bits [i*16 +: 16].
    logic [DEPTH*16-1:0] mem;
    logic [DEPTH*16-1:0] mem_next;
    logic [CW-1:0]       wr_idx;

    // The tail slot is computed after the pop has been applied.
    assign wr_idx = count - CW'(pop);

    always_comb begin
        mem_next = mem >> {pop, 4'b0000};
        for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_idx == CW'(i))) begin
                mem_next[i*16 +: 16] = push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem   <= '0;
            count <= '0;
        end else if (clr) begin
            // Stale contents are left in place; count alone defines validity.
            count <= '0;
        end else begin
            mem   <= mem_next;
            count <= count - CW'(pop) + CW'(push);
        end
    end

    assign head0 = mem[15:0];
    assign head1 = mem[31:16];

endmodule

// File: rtl/tinyqv_instr_prefetch.sv
// Instruction prefetch buffer for TinyQV.
//
// Requests halfwords from the memory controller, buffers them and presents the
// two oldest to the CPU. A CPU jump flushes the buffer and redirects the fetch.
//
// Ports:
//   clk, rstn            - clock, asynchronous active-low reset
//   instr_jump           - CPU redirect, flushes the buffer
//   instr_jump_addr      - redirect halfword address [23:1]
//   instr_consume        - halfwords taken by the CPU this cycle (0..2)
//   instr_data_out       - {entry1, entry0}, entry0 is the head
//   instr_count          - valid halfwords held
//   instr_pc             - address of the head entry
//   instr_addr           - next halfword fetch address to the memory controller
//   instr_fetch_restart  - request a fetch start at instr_addr
//   instr_fetch_stall    - ask the memory controller to hold
//   instr_fetch_started  - pulse: controller began a fetch
//   instr_fetch_stopped  - pulse: controller ended a fetch
//   instr_data           - fetched halfword
//   instr_ready          - instr_data valid this cycle
//   dbg_state            - current controller state (pf_state_e encoding)
//
// Handshake: instr_ready is a one-cycle strobe with no back-pressure; the
// prefetcher throttles the controller with instr_fetch_stall one entry ahead
// of full, and the CPU's instr_consume is a same-cycle take of up to two
// entries, clamped to what is held.
module tinyqv_instr_prefetch
    import tinyqv_pkg::*;
#(
    parameter logic [23:1] RESET_ADDR = 23'h000000,
    parameter int          DEPTH      = PF_DEPTH
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        instr_jump,
    input  logic [23:1] instr_jump_addr,
    input  logic [1:0]  instr_consume,
    output logic [31:0] instr_data_out,
    output logic [2:0]  instr_count,
    output logic [23:1] instr_pc,
    output logic [23:1] instr_addr,
    output logic        instr_fetch_restart,
    output logic        instr_fetch_stall,
    input  logic        instr_fetch_started,
    input  logic        instr_fetch_stopped,
    input  logic [15:0] instr_data,
    input  logic        instr_ready,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_C = CW'(DEPTH - 1);

    pf_state_e     state;
    logic          active;     // controller has started and not yet stopped
    logic          jump_q;     // jump seen last cycle
    logic [CW-1:0] count;
    logic [1:0]    pop;
    logic          push;
    logic          fetch_live;
    logic [15:0]   head0;
    logic [15:0]   head1;

    // CPU may ask for more than is held; only take what exists.
    assign pop = (CW'(instr_consume) > count) ? count[1:0] : instr_consume;

    // A full buffer still accepts data when the CPU frees a slot this cycle.
    assign push = (state == PF_FETCH) && instr_ready && !instr_jump &&
                  ((count != FULL_C) || (pop != 2'd0));

    // A start pulse arriving with the jump belongs to the old fetch stream.
    assign fetch_live = active || instr_fetch_started;

    tinyqv_hw_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (instr_jump),
        .push      (push),
        .push_data (instr_data),
        .pop       (pop),
        .head0     (head0),
        .head1     (head1),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= PF_RESTART;
            active     <= 1'b0;
            jump_q     <= 1'b0;
            instr_addr <= RESET_ADDR;
            instr_pc   <= RESET_ADDR;
        end else begin
            jump_q <= instr_jump;

            if (instr_fetch_started) begin
                active <= 1'b1;
            end else if (instr_fetch_stopped) begin
                active <= 1'b0;
            end

            if (instr_jump) begin
                instr_addr <= instr_jump_addr;
                instr_pc   <= instr_jump_addr;
                state      <= fetch_live ? PF_FLUSH : PF_RESTART;
            end else begin
                instr_pc <= instr_pc + 23'(pop);
                if (push) begin
                    instr_addr <= instr_addr + 23'd1;
                end
                case (state)
                    PF_RESTART: begin
                        // Start pulse right after a jump answers the old request.
                        if (instr_fetch_started) begin
                            state <= jump_q ? PF_FLUSH : PF_FETCH;
                        end
                    end
                    PF_FETCH: begin
                        if (instr_fetch_stopped) state <= PF_RESTART;
                    end
                    PF_FLUSH: begin
                        if (instr_fetch_stopped) state <= PF_RESTART;
                    end
                    default: state <= PF_RESTART;
                endcase
            end
        end
    end

    assign instr_fetch_restart = (state != PF_FETCH);
    assign instr_fetch_stall   = (state == PF_FLUSH) || (count >= STALL_C);
    assign instr_count         = 3'(count);
    assign instr_data_out      = {head1, head0};
    assign dbg_state           = state;

endmodule

// File: tb/tb_tinyqv_instr_prefetch.sv
// Testbench for tinyqv_instr_prefetch: directed scenarios followed by a
// randomized memory-controller / CPU stream checked against a queue model.
module tb_tinyqv_instr_prefetch;
    import tinyqv_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [23:1] RST_ADDR = 23'h000000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        instr_jump;
    logic [23:1] instr_jump_addr;
    logic [1:0]  instr_consume;
    logic [31:0] instr_data_out;
    logic [2:0]  instr_count;
    logic [23:1] instr_pc;
    logic [23:1] instr_addr;
    logic        instr_fetch_restart;
    logic        instr_fetch_stall;
    logic        instr_fetch_started;
    logic        instr_fetch_stopped;
    logic [15:0] instr_data;
    logic        instr_ready;
    logic [1:0]  dbg_state;

    tinyqv_instr_prefetch #(
        .RESET_ADDR (RST_ADDR),
        .DEPTH      (DEPTH)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .instr_jump          (instr_jump),
        .instr_jump_addr     (instr_jump_addr),
        .instr_consume       (instr_consume),
        .instr_data_out      (instr_data_out),
        .instr_count         (instr_count),
        .instr_pc            (instr_pc),
        .instr_addr          (instr_addr),
        .instr_fetch_restart (instr_fetch_restart),
        .instr_fetch_stall   (instr_fetch_stall),
        .instr_fetch_started (instr_fetch_started),
        .instr_fetch_stopped (instr_fetch_stopped),
        .instr_data          (instr_data),
        .instr_ready         (instr_ready),
        .dbg_state           (dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int total = 0;
    int bad   = 0;

    localparam int M_RESTART = 0;
    localparam int M_FETCH   = 1;
    localparam int M_FLUSH   = 2;

    int          mode;
    bit          m_active;
    bit          m_jump_prev;
    logic [23:1] m_addr;
    logic [23:1] m_pc;
    logic [15:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mode        = M_RESTART;
        m_active    = 1'b0;
        m_jump_prev = 1'b0;
        m_addr      = RST_ADDR;
        m_pc        = RST_ADDR;
        exp_q.delete();
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int c;
        if (instr_jump) begin
            mode = (m_active || instr_fetch_started) ? M_FLUSH : M_RESTART;
            exp_q.delete();
            m_addr = instr_jump_addr;
            m_pc   = instr_jump_addr;
        end else begin
            c = (int'(instr_consume) < exp_q.size()) ? int'(instr_consume) : exp_q.size();
            for (int i = 0; i < c; i++) void'(exp_q.pop_front());
            m_pc = m_pc + 23'(c);
            if (mode == M_FETCH && instr_ready) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back(instr_data);
                    m_addr = m_addr + 23'd1;
                end else begin
                    total++;
                    bad++;
                    $error("FAIL overflow: got ready with %0d entries want room", exp_q.size());
                end
            end
            case (mode)
                M_RESTART: if (instr_fetch_started) mode = m_jump_prev ? M_FLUSH : M_FETCH;
                M_FETCH:   if (instr_fetch_stopped) mode = M_RESTART;
                M_FLUSH:   if (instr_fetch_stopped) mode = M_RESTART;
                default:   mode = M_RESTART;
            endcase
        end
        if (instr_fetch_started)      m_active = 1'b1;
        else if (instr_fetch_stopped) m_active = 1'b0;
        m_jump_prev = instr_jump;
    endtask

    task automatic check_model();
        pf_state_e es;
        es = (mode == M_FETCH) ? PF_FETCH : (mode == M_FLUSH) ? PF_FLUSH : PF_RESTART;
        chk("count",   32'(instr_count), 32'(exp_q.size()));
        chk("pc",      32'(instr_pc), 32'(m_pc));
        chk("addr",    32'(instr_addr), 32'(m_addr));
        chk("state",   32'(dbg_state), 32'(es));
        chk("restart", 32'(instr_fetch_restart), 32'(mode != M_FETCH));
        chk("stall",   32'(instr_fetch_stall),
            32'((mode == M_FLUSH) || (exp_q.size() >= DEPTH - 1)));
        if (exp_q.size() >= 1) chk("head0", 32'(instr_data_out[15:0]), 32'(exp_q[0]));
        if (exp_q.size() >= 2) chk("head1", 32'(instr_data_out[31:16]), 32'(exp_q[1]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_in(input bit j, input logic [23:1] ja, input logic [1:0] cons,
                          input bit st, input bit sp, input bit rd, input logic [15:0] d);
        instr_jump          = j;
        instr_jump_addr     = ja;
        instr_consume       = cons;
        instr_fetch_started = st;
        instr_fetch_stopped = sp;
        instr_ready         = rd;
        instr_data          = d;
    endtask

    task automatic idle();
        set_in(1'b0, 23'h0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    // One clock: model follows the driven inputs, DUT sampled 1ns after the edge.
    task automatic tick();
        if (!rstn) model_reset();
        else       model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] prog [4];

    initial begin
        logic        j, st, sp, rd;
        logic [23:1] ja;
        logic [1:0]  cons;
        int          after;

        prog[0] = 16'h0013;
        prog[1] = 16'h0001;
        prog[2] = 16'h4501;
        prog[3] = 16'h0002;

        rstn = 1'b0;
        idle();
        model_reset();
        tick();
        tick();
        chk("rst_count",   32'(instr_count), 32'd0);
        chk("rst_restart", 32'(instr_fetch_restart), 32'd1);
        chk("rst_stall",   32'(instr_fetch_stall), 32'd0);
        chk("rst_addr",    32'(instr_addr), 32'(RST_ADDR));
        rstn = 1'b1;

        // Reset release, start one cycle later, four halfwords.
        tick();
        set_in(1'b0, 23'h0, 2'd0, 1'b1, 1'b0, 1'b0, 16'h0);
        tick();
        chk("start_state", 32'(dbg_state), 32'(PF_FETCH));
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 23'h0, 2'd0, 1'b0, 1'b0, 1'b1, prog[i]);
            tick();
            if (i == 1) chk("stall_at_2", 32'(instr_fetch_stall), 32'd0);
            if (i == 2) chk("stall_at_3", 32'(instr_fetch_stall), 32'd1);
        end
        idle();
        chk("fill_count", 32'(instr_count), 32'd4);
        chk("fill_addr",  32'(instr_addr), 32'd4);
        chk("fill_data",  instr_data_out, 32'h00010013);

        // Full buffer: consume two and accept one in the same cycle.
        set_in(1'b0, 23'h0, 2'd2, 1'b0, 1'b0, 1'b1, 16'h0005);
        tick();
        idle();
        chk("cr_count", 32'(instr_count), 32'd3);
        chk("cr_pc",    32'(instr_pc), 32'd2);
        chk("cr_data",  instr_data_out, 32'h00024501);

        // Jump mid-fetch: flush, drop data, wait for stop.
        set_in(1'b1, 23'h000100, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        tick();
        chk("jf_count",   32'(instr_count), 32'd0);
        chk("jf_state",   32'(dbg_state), 32'(PF_FLUSH));
        chk("jf_restart", 32'(instr_fetch_restart), 32'd1);
        chk("jf_stall",   32'(instr_fetch_stall), 32'd1);
        set_in(1'b0, 23'h0, 2'd0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
        tick();
        chk("jf_drop", 32'(instr_count), 32'd0);
        set_in(1'b0, 23'h0, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0);
        tick();
        idle();
        chk("jf_stop_state", 32'(dbg_state), 32'(PF_RESTART));
        chk("jf_stop_addr",  32'(instr_addr), 32'h000100);

        // Jump in RESTART, start pulse on the following cycle is stale.
        set_in(1'b1, 23'h000200, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        tick();
        chk("js_state0", 32'(dbg_state), 32'(PF_RESTART));
        set_in(1'b0, 23'h0, 2'd0, 1'b1, 1'b0, 1'b0, 16'h0);
        tick();
        chk("js_state1", 32'(dbg_state), 32'(PF_FLUSH));
        set_in(1'b0, 23'h0, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0);
        tick();
        idle();
        chk("js_addr", 32'(instr_addr), 32'h000200);

        // Address wrap across a stop/restart.
        set_in(1'b1, 23'h7FFFFE, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0);
        tick();
        idle();
        tick();
        set_in(1'b0, 23'h0, 2'd0, 1'b1, 1'b0, 1'b0, 16'h0);
        tick();
        set_in(1'b0, 23'h0, 2'd0, 1'b0, 1'b0, 1'b1, 16'h1111);
        tick();
        chk("wr_addr_top", 32'(instr_addr), 32'h7FFFFF);
        set_in(1'b0, 23'h0, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0);
        tick();
        chk("wr_stop_state", 32'(dbg_state), 32'(PF_RESTART));
        chk("wr_keep_count", 32'(instr_count), 32'd1);
        chk("wr_restart",    32'(instr_fetch_restart), 32'd1);
        set_in(1'b0, 23'h0, 2'd0, 1'b1, 1'b0, 1'b0, 16'h0);
        tick();
        set_in(1'b0, 23'h0, 2'd0, 1'b0, 1'b0, 1'b1, 16'h2222);
        tick();
        chk("wr_addr_zero", 32'(instr_addr), 32'd0);
        chk("wr_data",      instr_data_out, 32'h22221111);

        // Asynchronous reset with three entries held.
        set_in(1'b0, 23'h0, 2'd0, 1'b0, 1'b0, 1'b1, 16'h3333);
        tick();
        idle();
        chk("ar_pre_count", 32'(instr_count), 32'd3);
        rstn = 1'b0;
        #1;
        chk("ar_count",   32'(instr_count), 32'd0);
        chk("ar_restart", 32'(instr_fetch_restart), 32'd1);
        chk("ar_addr",    32'(instr_addr), 32'(RST_ADDR));
        model_reset();
        tick();
        rstn = 1'b1;

        // Randomized controller / CPU traffic.
        for (int n = 0; n < 3000; n++) begin
            j  = ($urandom_range(0, 19) == 0);
            ja = ($urandom_range(0, 3) == 0) ? (23'h7FFFFF - 23'($urandom_range(0, 3)))
                                             : 23'($urandom);
            st = 1'b0;
            sp = 1'b0;
            if (!m_active) st = ($urandom_range(0, 3) == 0);
            else           sp = !j && ($urandom_range(0, 9) == 0);
            cons = 2'($urandom_range(0, 2));
            rd   = m_active && ($urandom_range(0, 1) == 1);
            after = exp_q.size() - ((int'(cons) < exp_q.size()) ? int'(cons) : exp_q.size());
            if (after >= DEPTH) rd = 1'b0;
            set_in(j, ja, cons, st, sp, rd, 16'($urandom));
            tick();
        end
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
